// File: rtl/cla_5bit_if.sv
// -----------------------------------------------------------------------------
// cla_5bit_if
// Purpose : bundles the operand and result signals of the 5-bit CLA adder.
// Signals :
//   a    [4:0]  operand A, unsigned        (master -> slave)
//   b    [4:0]  operand B, unsigned        (master -> slave)
//   sum  [4:0]  registered (a+b) mod 32    (slave -> master)
//   cout        registered carry-out       (slave -> master)
// Modports:
//   master : drives a/b, observes sum/cout (the datapath feeding the adder)
//   slave  : observes a/b, drives sum/cout (the adder itself)
// -----------------------------------------------------------------------------
interface cla_5bit_if;
   logic [4:0] a;
   logic [4:0] b;
   logic [4:0] sum;
   logic       cout;

   modport master (
      output a,
      output b,
      input  sum,
      input  cout
   );

   modport slave (
      input  a,
      input  b,
      output sum,
      output cout
   );
endinterface

// File: rtl/cla_5bit.sv
// -----------------------------------------------------------------------------
// cla_5bit
// Purpose : 5-bit unsigned adder built from a flat carry-lookahead network,
//           with a registered sum and carry-out. Carry-in is tied to 0.
// Ports   :
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every register
//   bus    slave modport of cla_5bit_if
//            bus.a, bus.b     operands (in)
//            bus.sum          registered (a+b) mod 32 (out)
//            bus.cout         registered bit 5 of a+b (out)
// Config  :
//   CLA_5BIT_INREG_EN  defined   -> a/b are registered first, latency 2 cycles
//                      undefined -> a/b feed the CLA directly, latency 1 cycle
//   The arithmetic result is identical in both builds.
// -----------------------------------------------------------------------------
module cla_5bit (
   input  logic        clk,
   input  logic        rst_n,
   cla_5bit_if.slave   bus
);

   // ---------------------------------------------------------------------------
   // Operand source: optional input register stage
   // ---------------------------------------------------------------------------
   logic [4:0] w_a;
   logic [4:0] w_b;

`ifdef CLA_5BIT_INREG_EN
   logic [4:0] r_a;
   logic [4:0] r_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= 5'd0;
         r_b <= 5'd0;
      end else begin
         r_a <= bus.a;
         r_b <= bus.b;
      end
   end

   assign w_a = r_a;
   assign w_b = r_b;
`else
   assign w_a = bus.a;
   assign w_b = bus.b;
`endif

   // ---------------------------------------------------------------------------
   // Per-bit generate / propagate
   // ---------------------------------------------------------------------------
   logic [4:0] w_g;
   logic [4:0] w_p;

   assign w_g = w_a & w_b;
   assign w_p = w_a ^ w_b;

   // ---------------------------------------------------------------------------
   // Flat lookahead carries: every carry is a two-level sum of products of
   // g/p/c0, never built from the previous carry.
   // ---------------------------------------------------------------------------
   logic [5:0] w_c;

   assign w_c[0] = 1'b0;

   assign w_c[1] = w_g[0]
                 | (w_p[0] & w_c[0]);

   assign w_c[2] = w_g[1]
                 | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & w_c[0]);

   assign w_c[3] = w_g[2]
                 | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

   assign w_c[4] = w_g[3]
                 | (w_p[3] & w_g[2])
                 | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

   // ---------------------------------------------------------------------------
   // Group propagate / generate. Kept as separate terms so a future wider adder
   // can cascade this block; c[5] is expressed through them, which expands to
   // exactly the flat six-term product sum.
   // ---------------------------------------------------------------------------
   logic w_pg;
   logic w_gg;

   assign w_pg = &w_p;

   assign w_gg = w_g[4]
               | (w_p[4] & w_g[3])
               | (w_p[4] & w_p[3] & w_g[2])
               | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
               | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign w_c[5] = w_gg | (w_pg & w_c[0]);

   // ---------------------------------------------------------------------------
   // Sum and carry-out
   // ---------------------------------------------------------------------------
   logic [4:0] w_sum;
   logic       w_cout;

   assign w_sum  = w_p ^ w_c[4:0];
   assign w_cout = w_c[5];

   // ---------------------------------------------------------------------------
   // Result register; reset clears it immediately, discarding any result
   // that was in flight.
   // ---------------------------------------------------------------------------
   logic [4:0] r_sum;
   logic       r_cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= 5'd0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_cout;
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule

// File: tb/tb_cla_5bit.sv
// -----------------------------------------------------------------------------
// tb_cla_5bit
// Directed self-checking bench for cla_5bit. Build with +define+CLA_5BIT_INREG_EN
// to exercise the two-cycle configuration; the expected latency follows it.
// -----------------------------------------------------------------------------
module tb_cla_5bit;

`ifdef CLA_5BIT_INREG_EN
   localparam int Lat = 2;
`else
   localparam int Lat = 1;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   cla_5bit_if u_if ();

   cla_5bit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got {cout,sum}=%0d (%b) expected %0d (%b)", tag, obs, obs, exp, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [5:0] result();
      return {u_if.cout, u_if.sum};
   endfunction

   // Directed vectors with hand-computed {cout,sum}.
   logic [4:0] vec_a [4] = '{5'd10, 5'd0, 5'd31, 5'd31};
   logic [4:0] vec_b [4] = '{5'd5,  5'd0, 5'd31, 5'd1};
   logic [5:0] vec_e [4] = '{6'd15, 6'd0, 6'd62, 6'd32};

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b1;
      u_if.a   = 5'd22;
      u_if.b   = 5'd13;

      // Reset takes effect with no clock edge (first posedge is at t=5).
      #1 rst_n = 1'b0;
      #1 check_eq("reset_no_edge", result(), 6'd0);

      tick(2);
      check_eq("reset_held", result(), 6'd0);

      // Release between edges, then two edges: 22+13 = 35 -> sum 3, cout 1.
      rst_n = 1'b1;
      tick(2);
      check_eq("22+13", result(), 6'd35);

      // New operands do not disturb the registered result before an edge.
      u_if.a = 5'd15;
      u_if.b = 5'd23;
      #3 check_eq("hold_between_edges", result(), 6'd35);
      tick(Lat);
      check_eq("15+23", result(), 6'd38);

      for (int i = 0; i < 4; i++) begin
         u_if.a = vec_a[i];
         u_if.b = vec_b[i];
         tick(Lat);
         check_eq($sformatf("vec%0d %0d+%0d", i, vec_a[i], vec_b[i]), result(), vec_e[i]);
      end

      // Mid-stream reset: 31+31 settled, then a low pulse between edges.
      u_if.a = 5'd31;
      u_if.b = 5'd31;
      tick(Lat);
      check_eq("31+31_pre_reset", result(), 6'd62);
      #2 rst_n = 1'b0;
      #1 check_eq("mid_reset_async", result(), 6'd0);
      #1 rst_n = 1'b1;
      #1 check_eq("mid_reset_released_no_edge", result(), 6'd0);
      tick(Lat);
      check_eq("31+31_after_reset", result(), 6'd62);

      // Exhaustive sweep.
      for (int ia = 0; ia < 32; ia++) begin
         for (int ib = 0; ib < 32; ib++) begin
            u_if.a = 5'(ia);
            u_if.b = 5'(ib);
            tick(Lat);
            if ({u_if.cout, u_if.sum} !== 6'(ia + ib)) begin
               check_eq($sformatf("sweep %0d+%0d", ia, ib), result(), 6'(ia + ib));
            end else begin
               n_checks++;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
